axi_lite_req_arbiter: RTL and testbench
=======================================

AXI_LITE_REQ_ARBITER -- requirements
Module: axi_lite_req_arbiter

Interface
REQ-001 SHALL have parameter RR_MODE, default 0, meaning 0 = fixed priority and 1 = round-robin.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the maximum BUSY cycles before forced release; 0 disables the timeout.
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port ARESETN, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 4 bits: request from requesters 3..0; level-sensitive.
REQ-006 SHALL have port done, input, 1 bit: current owner's transaction is complete (e.g. BVALID&&BREADY from the slave side).
REQ-007 SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-008 SHALL have port gnt_id, output, 2 bits: binary index of the granted requester, registered.
REQ-009 SHALL have port gnt_valid, output, 1 bit: high exactly when gnt is nonzero.
REQ-010 SHALL have port timeout_err, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-011 SHALL implement exactly two states: IDLE and BUSY.
REQ-012 In IDLE with req==0, SHALL stay in IDLE with gnt=0, gnt_valid=0 and gnt_id holding its last value.
REQ-013 In IDLE with req!=0, SHALL select a winner combinationally, register gnt/gnt_id/gnt_valid at the next edge, and enter BUSY (one-cycle grant latency).
REQ-014 With RR_MODE=0, SHALL use fixed order 3>2>1>0, so the highest set req bit wins.
REQ-015 With RR_MODE=1, SHALL search in order (L-1),(L-2),(L-3),L mod 4, where L is the last granted index; first set req wins.
REQ-016 SHALL update L only when a grant is issued; L resets to 0, so the first RR search order is 3,2,1,0.
REQ-017 In BUSY, SHALL hold gnt, gnt_id and gnt_valid stable regardless of req changes, including the owner deasserting req.
REQ-018 In BUSY with done=1, SHALL return to IDLE at the next edge with gnt=0 and gnt_valid=0.
REQ-019 After any release, SHALL keep gnt=0 for at least one full cycle before the next grant (back-to-back: done at edge N, new gnt at edge N+2).
REQ-020 SHALL ignore done while in IDLE.
REQ-021 With TIMEOUT>0, SHALL count cycles spent in BUSY, starting at 0 on grant and incrementing each BUSY cycle without done.
REQ-022 When the count reaches TIMEOUT-1 without done, SHALL go to IDLE at the next edge, clear the grant, and pulse timeout_err for exactly one cycle.
REQ-023 If done and timeout coincide in the same cycle, done SHALL take precedence and timeout_err SHALL stay 0.
REQ-024 The timeout counter SHALL be wide enough for TIMEOUT and SHALL never wrap.
REQ-025 gnt SHALL never have more than one bit set.
REQ-026 gnt_valid SHALL equal |gnt in every cycle.

Reset
REQ-027 ARESETN low SHALL immediately force state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout_err=0, L=0 and counter=0.
REQ-028 Reset asserted during BUSY SHALL drop the grant without waiting for done.
REQ-029 After ARESETN deasserts, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-030 Fixed priority: RR_MODE=0, req=4'b0110 in IDLE -> next cycle gnt=4'b0100, gnt_id=2, gnt_valid=1.
REQ-031 Hold: while granted to 2, req changes to 4'b1000 and no done for 5 cycles -> gnt stays 4'b0100 throughout.
REQ-032 Round-robin: RR_MODE=1, req=4'b1111 held, done pulsed each grant -> grant sequence 3,2,1,0,3 with one gnt=0 cycle between each grant.
REQ-033 Timeout: TIMEOUT=4, grant to 1, done never asserted -> gnt clears after 4 BUSY cycles, timeout_err=1 for one cycle, then re-arbitration.
REQ-034 Coincidence: done asserted on the cycle the count reaches 3 (TIMEOUT=4) -> release with timeout_err=0.
REQ-035 Reset mid-grant: ARESETN pulled low while gnt=4'b0001 -> all outputs 0 asynchronously; after release, req=4'b0001 is granted again.

Source files
------------

// File: rtl/axi_lite_req_arbiter_if.sv
// Request/grant bundle between four requesters and the arbiter.
//   req[3:0]     level-sensitive requests from requesters 3..0
//   done         the current owner's transaction has completed
//   gnt[3:0]     one-hot grant (registered)
//   gnt_id[1:0]  binary index of the granted requester (registered)
//   gnt_valid    high exactly when gnt is nonzero
//   timeout_err  one-cycle pulse when a grant is forcibly released
// modport master: requester side; modport slave: arbiter side.
interface axi_lite_req_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout_err;

    modport master (
        output req, done,
        input  gnt, gnt_id, gnt_valid, timeout_err
    );

    modport slave (
        input  req, done,
        output gnt, gnt_id, gnt_valid, timeout_err
    );
endinterface

// File: rtl/axi_lite_req_arbiter.sv
// Four-way request arbiter with a two-state IDLE/BUSY FSM.
//   ACLK     clock, all state changes on the rising edge
//   ARESETN  asynchronous active-low reset
//   bus      axi_lite_req_arbiter_if.slave: req/done in, gnt/gnt_id/gnt_valid/timeout_err out
// Parameters:
//   RR_MODE  0 = fixed priority 3>2>1>0, 1 = round-robin from the last granted index
//   TIMEOUT  maximum BUSY cycles before a forced release; 0 disables the timeout
module axi_lite_req_arbiter #(
    parameter int unsigned RR_MODE = 0,
    parameter int unsigned TIMEOUT = 16
) (
    input logic                    ACLK,
    input logic                    ARESETN,
    axi_lite_req_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {StIdle, StBusy} state_t;

    state_t          state_q;
    logic [1:0]      last_q;
    logic [CW-1:0]   cnt_q;
    logic            armed_q;

    logic [1:0]      win;
    logic [1:0]      idx;
    logic            to_hit;

    // Winner selection: the last candidate written in each loop has priority.
    always_comb begin
        win = '0;
        idx = '0;
        if (RR_MODE != 0) begin
            // Search order last-1, last-2, last-3, last (mod 4).
            for (int k = 4; k >= 1; k--) begin
                idx = last_q - 2'(k);
                if (bus.req[idx]) win = idx;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req[i]) win = 2'(i);
            end
        end
    end

    assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q         <= StIdle;
            last_q          <= '0;
            cnt_q           <= '0;
            armed_q         <= 1'b0;
            bus.gnt         <= '0;
            bus.gnt_id      <= '0;
            bus.gnt_valid   <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            // First edge after reset only arms the arbiter, so no grant lands on it.
            armed_q         <= 1'b1;
            bus.timeout_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (armed_q && (|bus.req)) begin
                        bus.gnt       <= 4'b0001 << win;
                        bus.gnt_id    <= win;
                        bus.gnt_valid <= 1'b1;
                        last_q        <= win;
                        cnt_q         <= '0;
                        state_q       <= StBusy;
                    end
                end
                StBusy: begin
                    // done wins over a coincident timeout.
                    if (bus.done || to_hit) begin
                        bus.gnt         <= '0;
                        bus.gnt_valid   <= 1'b0;
                        bus.timeout_err <= !bus.done;
                        state_q         <= StIdle;
                    end else if (TIMEOUT != 0) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
module tb_axi_lite_req_arbiter;

    logic ACLK = 1'b0;
    logic ARESETN;

    always #5 ACLK = ~ACLK;

    axi_lite_req_arbiter_if f_if ();
    axi_lite_req_arbiter_if r_if ();
    axi_lite_req_arbiter_if t_if ();

    axi_lite_req_arbiter #(.RR_MODE(0), .TIMEOUT(16)) u_fix (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (f_if)
    );

    axi_lite_req_arbiter #(.RR_MODE(1), .TIMEOUT(16)) u_rr (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (r_if)
    );

    axi_lite_req_arbiter #(.RR_MODE(0), .TIMEOUT(4)) u_to (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (t_if)
    );

    int errors = 0;
    int checks = 0;
    int rr_exp [5] = '{3, 2, 1, 0, 3};

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        f_if.req = '0; f_if.done = 1'b0;
        r_if.req = '0; r_if.done = 1'b0;
        t_if.req = '0; t_if.done = 1'b0;
        tick();
        tick();
        check("rst_gnt",   8'(f_if.gnt), 8'h0);
        check("rst_id",    8'(f_if.gnt_id), 8'h0);
        check("rst_valid", 8'(f_if.gnt_valid), 8'h0);
        check("rst_terr",  8'(t_if.timeout_err), 8'h0);

        // Release reset with a request already pending: no grant on the first edge.
        ARESETN  = 1'b1;
        f_if.req = 4'b0110;
        tick();
        check("first_edge_no_gnt", 8'(f_if.gnt), 8'h0);
        tick();
        check("fix_gnt",   8'(f_if.gnt), 8'h04);
        check("fix_id",    8'(f_if.gnt_id), 8'h2);
        check("fix_valid", 8'(f_if.gnt_valid), 8'h1);

        // Hold while requests change.
        f_if.req = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_gnt", 8'(f_if.gnt), 8'h04);
        end

        f_if.done = 1'b1;
        tick();
        check("rel_gnt",   8'(f_if.gnt), 8'h0);
        check("rel_valid", 8'(f_if.gnt_valid), 8'h0);
        check("rel_id",    8'(f_if.gnt_id), 8'h2);
        f_if.done = 1'b0;
        tick();
        check("b2b_gnt", 8'(f_if.gnt), 8'h08);
        check("b2b_id",  8'(f_if.gnt_id), 8'h3);

        // done held into IDLE with no request is ignored; gnt_id holds.
        f_if.done = 1'b1;
        f_if.req  = 4'b0000;
        tick();
        check("rel2_gnt", 8'(f_if.gnt), 8'h0);
        tick();
        check("idle_done_gnt",   8'(f_if.gnt), 8'h0);
        check("idle_done_valid", 8'(f_if.gnt_valid), 8'h0);
        check("idle_id_hold",    8'(f_if.gnt_id), 8'h3);
        f_if.done = 1'b0;

        f_if.req = 4'b0011;
        tick();
        check("fix2_gnt", 8'(f_if.gnt), 8'h02);
        check("fix2_id",  8'(f_if.gnt_id), 8'h1);
        f_if.done = 1'b1;
        f_if.req  = 4'b0000;
        tick();
        check("fix2_rel", 8'(f_if.gnt), 8'h0);
        f_if.done = 1'b0;

        // Round-robin with all requests held.
        r_if.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_id",    8'(r_if.gnt_id), 8'(rr_exp[i]));
            check("rr_gnt",   8'(r_if.gnt), 8'(4'b0001 << rr_exp[i]));
            check("rr_valid", 8'(r_if.gnt_valid), 8'h1);
            r_if.done = 1'b1;
            tick();
            check("rr_gap", 8'(r_if.gnt), 8'h0);
            r_if.done = 1'b0;
        end
        // Last grant was 3: search 2,1,0,3 then from 2: 1,0,3,2.
        r_if.req = 4'b0101;
        tick();
        check("rr_part1", 8'(r_if.gnt_id), 8'h2);
        r_if.done = 1'b1;
        tick();
        r_if.done = 1'b0;
        tick();
        check("rr_part2", 8'(r_if.gnt_id), 8'h0);
        r_if.done = 1'b1;
        r_if.req  = 4'b0000;
        tick();
        r_if.done = 1'b0;

        // Timeout: TIMEOUT=4 gives four BUSY cycles then a forced release.
        t_if.req = 4'b0010;
        tick();
        check("to_gnt",  8'(t_if.gnt), 8'h02);
        check("to_terr", 8'(t_if.timeout_err), 8'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_busy_gnt",  8'(t_if.gnt), 8'h02);
            check("to_busy_terr", 8'(t_if.timeout_err), 8'h0);
        end
        tick();
        check("to_rel_gnt",   8'(t_if.gnt), 8'h0);
        check("to_rel_valid", 8'(t_if.gnt_valid), 8'h0);
        check("to_rel_terr",  8'(t_if.timeout_err), 8'h1);
        tick();
        check("to_regnt",      8'(t_if.gnt), 8'h02);
        check("to_terr_pulse", 8'(t_if.timeout_err), 8'h0);

        // done arrives in the cycle the count is at 3.
        for (int i = 0; i < 3; i++) tick();
        check("co_busy", 8'(t_if.gnt), 8'h02);
        t_if.done = 1'b1;
        tick();
        check("co_gnt",  8'(t_if.gnt), 8'h0);
        check("co_terr", 8'(t_if.timeout_err), 8'h0);
        t_if.done = 1'b0;
        t_if.req  = 4'b0000;
        tick();
        check("co_terr2", 8'(t_if.timeout_err), 8'h0);

        // Reset in the middle of a grant.
        f_if.req = 4'b0001;
        tick();
        check("mid_gnt", 8'(f_if.gnt), 8'h01);
        ARESETN = 1'b0;
        #1;
        check("mid_rst_gnt",   8'(f_if.gnt), 8'h0);
        check("mid_rst_id",    8'(f_if.gnt_id), 8'h0);
        check("mid_rst_valid", 8'(f_if.gnt_valid), 8'h0);
        check("mid_rst_terr",  8'(f_if.timeout_err), 8'h0);
        tick();
        ARESETN = 1'b1;
        tick();
        check("post_rst_first", 8'(f_if.gnt), 8'h0);
        tick();
        check("post_rst_gnt",   8'(f_if.gnt), 8'h01);
        check("post_rst_id",    8'(f_if.gnt_id), 8'h0);
        check("post_rst_valid", 8'(f_if.gnt_valid), 8'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
